// File: rtl/nrisc_pkg.sv
// nrisc_pkg: constants shared by the CPU control unit and the return-address stack.
//   STACK_ctrl command encodings, the default PC/return-address width and the
//   stack controller state type.
package nrisc_pkg;

    localparam int NRISC_ADDR_W = 16;

    localparam logic [1:0] STACK_IDLE = 2'b00;
    localparam logic [1:0] STACK_PUSH = 2'b01;
    localparam logic [1:0] STACK_POP  = 2'b10;
    localparam logic [1:0] STACK_RSVD = 2'b11;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_POPPED = 1'b1
    } stack_state_t;

endpackage

// File: rtl/nrisc_stack_if.sv
// nrisc_stack_if: CPU <-> return-address stack signal bundle.
//   master : CPU side (drives STACK_ctrl, STACK_DataIN, STACK_err_clr)
//   slave  : stack side (drives STACK_DataOUT, STACK_count, flags, pop_valid)
// Optional error signals present when NRISC_STACK_ERR_EN is defined.
interface nrisc_stack_if #(
    parameter int STACK_DEPTH = 16,
    parameter int ADDR_W      = nrisc_pkg::NRISC_ADDR_W
);
    localparam int CNT_W = $clog2(STACK_DEPTH) + 1;

    logic [1:0]        STACK_ctrl;
    logic [ADDR_W-1:0] STACK_DataIN;
    logic [ADDR_W-1:0] STACK_DataOUT;
    logic [CNT_W-1:0]  STACK_count;
    logic              STACK_empty;
    logic              STACK_full;
    logic              STACK_pop_valid;
`ifdef NRISC_STACK_ERR_EN
    logic              STACK_overflow;
    logic              STACK_underflow;
    logic              STACK_err_clr;
`endif

    modport master (
        output STACK_ctrl, STACK_DataIN,
        input  STACK_DataOUT, STACK_count, STACK_empty, STACK_full, STACK_pop_valid
`ifdef NRISC_STACK_ERR_EN
        , output STACK_err_clr
        , input  STACK_overflow, STACK_underflow
`endif
    );

    modport slave (
        input  STACK_ctrl, STACK_DataIN,
        output STACK_DataOUT, STACK_count, STACK_empty, STACK_full, STACK_pop_valid
`ifdef NRISC_STACK_ERR_EN
        , input  STACK_err_clr
        , output STACK_overflow, STACK_underflow
`endif
    );

endinterface

// File: rtl/nrisc_stack_ram.sv
// nrisc_stack_ram: DEPTH x ADDR_W storage, single synchronous write port,
// asynchronous read port. No reset on the array.
//   clk   : clock
//   we    : write enable
//   waddr : write index
//   wdata : write data
//   raddr : read index
//   rdata : read data (combinational)
module nrisc_stack_ram #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/nrisc_stack.sv
// nrisc_stack: hardware return-address stack for CALL/RET.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : nrisc_stack_if.slave (command, push data, registered top-of-stack,
//         count, empty/full, one-cycle pop_valid pulse)
// Optional build macro NRISC_STACK_ERR_EN adds sticky overflow/underflow
// flags with STACK_err_clr.
//
// state     | meaning
// ST_IDLE   | no pop accepted on the previous edge
// ST_POPPED | pop accepted on the previous edge; STACK_pop_valid high
module nrisc_stack
    import nrisc_pkg::*;
#(
    parameter int STACK_DEPTH = 16,
    parameter int ADDR_W      = NRISC_ADDR_W
) (
    input logic          clk,
    input logic          rst,
    nrisc_stack_if.slave bus
);

    localparam int IDX_W = $clog2(STACK_DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [CNT_W-1:0]  count;
    logic [ADDR_W-1:0] dout;
    logic [ADDR_W-1:0] rdata;
    logic [IDX_W-1:0]  raddr;
    logic              empty;
    logic              full;
    logic              push_ok;
    logic              pop_ok;
    stack_state_t      state;
    stack_state_t      state_nxt;
    logic              pop_valid;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(STACK_DEPTH));
    assign push_ok = (bus.STACK_ctrl == STACK_PUSH) && !full;
    assign pop_ok  = (bus.STACK_ctrl == STACK_POP) && !empty;

    // After a pop the new top sits two below the current count.
    assign raddr = count[IDX_W-1:0] - IDX_W'(2);

    nrisc_stack_ram #(
        .DEPTH  (STACK_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (push_ok),
        .waddr (count[IDX_W-1:0]),
        .wdata (bus.STACK_DataIN),
        .raddr (raddr),
        .rdata (rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            dout  <= '0;
        end else if (push_ok) begin
            count <= count + CNT_W'(1);
            dout  <= bus.STACK_DataIN;
        end else if (pop_ok) begin
            count <= count - CNT_W'(1);
            dout  <= (count >= CNT_W'(2)) ? rdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        pop_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pop_ok) state_nxt = ST_POPPED;
            end
            ST_POPPED: begin
                pop_valid = 1'b1;
                if (pop_ok) state_nxt = ST_POPPED;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.STACK_DataOUT   = dout;
    assign bus.STACK_count     = count;
    assign bus.STACK_empty     = empty;
    assign bus.STACK_full      = full;
    assign bus.STACK_pop_valid = pop_valid;

`ifdef NRISC_STACK_ERR_EN
    logic overflow;
    logic underflow;
    logic push_drop;
    logic pop_drop;

    assign push_drop = (bus.STACK_ctrl == STACK_PUSH) && full;
    assign pop_drop  = (bus.STACK_ctrl == STACK_POP) && empty;

    // A same-edge error event wins over the clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push_drop)              overflow  <= 1'b1;
            else if (bus.STACK_err_clr) overflow  <= 1'b0;
            if (pop_drop)               underflow <= 1'b1;
            else if (bus.STACK_err_clr) underflow <= 1'b0;
        end
    end

    assign bus.STACK_overflow  = overflow;
    assign bus.STACK_underflow = underflow;
`endif

endmodule

// File: tb/tb_nrisc_stack.sv
// tb_nrisc_stack: directed scenarios plus randomized command streams checked
// against a queue-based model of the return-address stack.
module tb_nrisc_stack;
    import nrisc_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    nrisc_stack_if #(.STACK_DEPTH(DEPTH), .ADDR_W(AW)) bus ();

    nrisc_stack #(.STACK_DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fails  = 0;

    logic [AW-1:0] mdl_q[$];
    logic          mdl_pv  = 1'b0;
    logic          mdl_ovf = 1'b0;
    logic          mdl_unf = 1'b0;
    logic          err_clr = 1'b0;

`ifdef NRISC_STACK_ERR_EN
    assign bus.STACK_err_clr = err_clr;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        logic [AW-1:0] top;
        top = (mdl_q.size() > 0) ? mdl_q[mdl_q.size()-1] : '0;
        check({tag, ".dout"},  32'(bus.STACK_DataOUT), 32'(top));
        check({tag, ".count"}, 32'(bus.STACK_count), 32'(mdl_q.size()));
        check({tag, ".empty"}, 32'(bus.STACK_empty), 32'(mdl_q.size() == 0));
        check({tag, ".full"},  32'(bus.STACK_full), 32'(mdl_q.size() == DEPTH));
        check({tag, ".pv"},    32'(bus.STACK_pop_valid), 32'(mdl_pv));
`ifdef NRISC_STACK_ERR_EN
        check({tag, ".ovf"},   32'(bus.STACK_overflow), 32'(mdl_ovf));
        check({tag, ".unf"},   32'(bus.STACK_underflow), 32'(mdl_unf));
`endif
    endtask

    // Apply one command for one edge, advance the model, then compare.
    task automatic step(input string tag, input logic r, input logic [1:0] ctrl,
                        input logic [AW-1:0] din, input logic clr);
        logic ovf_ev;
        logic unf_ev;
        rst              = r;
        bus.STACK_ctrl   = ctrl;
        bus.STACK_DataIN = din;
        err_clr          = clr;
        @(posedge clk);
        #1;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (r) begin
            mdl_q.delete();
            mdl_pv  = 1'b0;
            mdl_ovf = 1'b0;
            mdl_unf = 1'b0;
        end else begin
            mdl_pv = 1'b0;
            if (ctrl == 2'b01) begin
                if (mdl_q.size() < DEPTH) mdl_q.push_back(din);
                else ovf_ev = 1'b1;
            end else if (ctrl == 2'b10) begin
                if (mdl_q.size() > 0) begin
                    void'(mdl_q.pop_back());
                    mdl_pv = 1'b1;
                end else begin
                    unf_ev = 1'b1;
                end
            end
            if (ovf_ev) mdl_ovf = 1'b1; else if (clr) mdl_ovf = 1'b0;
            if (unf_ev) mdl_unf = 1'b1; else if (clr) mdl_unf = 1'b0;
        end
        rst            = 1'b0;
        bus.STACK_ctrl = 2'b00;
        err_clr        = 1'b0;
        check_all(tag);
    endtask

    initial begin
        bus.STACK_ctrl   = 2'b00;
        bus.STACK_DataIN = '0;

        // reset, single push
        step("reset", 1'b1, STACK_IDLE, 16'h0, 1'b0);
        step("push1", 1'b0, STACK_PUSH, 16'h0100, 1'b0);

        // three pushes then pop, pop_valid pulse length
        step("rst2", 1'b1, STACK_IDLE, 16'h0, 1'b0);
        step("p100", 1'b0, STACK_PUSH, 16'h0100, 1'b0);
        step("p200", 1'b0, STACK_PUSH, 16'h0200, 1'b0);
        step("p300", 1'b0, STACK_PUSH, 16'h0300, 1'b0);
        step("pop3", 1'b0, STACK_POP, 16'h0, 1'b0);
        check("pop3.dout_abs", 32'(bus.STACK_DataOUT), 32'h0200);
        step("pv_hi", 1'b0, STACK_IDLE, 16'h0, 1'b0);
        step("pv_lo", 1'b0, STACK_IDLE, 16'h0, 1'b0);
        // back-to-back pops keep pop_valid high
        step("popA", 1'b0, STACK_POP, 16'h0, 1'b0);
        step("popB", 1'b0, STACK_POP, 16'h0, 1'b0);
        step("popB1", 1'b0, STACK_IDLE, 16'h0, 1'b0);

        // fill, then overflow
        step("rst3", 1'b1, STACK_IDLE, 16'h0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step("fill", 1'b0, STACK_PUSH, AW'(16'h1000 + i), 1'b0);
        step("ovf", 1'b0, STACK_PUSH, 16'hDEAD, 1'b0);
        check("ovf.dout_abs", 32'(bus.STACK_DataOUT), 32'h100F);
        // drain completely to exercise every read index
        for (int i = 0; i < DEPTH; i++) step("drain", 1'b0, STACK_POP, 16'h0, 1'b0);

        // underflow, then clear; clear with same-edge underflow keeps flag
        step("unf", 1'b0, STACK_POP, 16'h0, 1'b0);
        step("unf_pv", 1'b0, STACK_IDLE, 16'h0, 1'b0);
        step("unf_clr_pri", 1'b0, STACK_POP, 16'h0, 1'b1);
        step("unf_clr", 1'b0, STACK_IDLE, 16'h0, 1'b1);

        // reset during pop of 3-deep stack
        step("p1", 1'b0, STACK_PUSH, 16'hA001, 1'b0);
        step("p2", 1'b0, STACK_PUSH, 16'hA002, 1'b0);
        step("p3", 1'b0, STACK_PUSH, 16'hA003, 1'b0);
        step("rst_pop", 1'b1, STACK_POP, 16'h0, 1'b0);
        step("rst_pop_after", 1'b0, STACK_IDLE, 16'h0, 1'b0);

        // reserved command with two entries
        step("r1", 1'b0, STACK_PUSH, 16'hB001, 1'b0);
        step("r2", 1'b0, STACK_PUSH, 16'hB002, 1'b0);
        for (int i = 0; i < 5; i++) step("rsvd", 1'b0, STACK_RSVD, AW'($urandom), 1'b0);

        // randomized phases with different push/pop bias
        for (int ph = 0; ph < 3; ph++) begin
            int push_pct;
            push_pct = (ph == 0) ? 70 : (ph == 1) ? 50 : 30;
            for (int i = 0; i < 200; i++) begin
                int roll;
                logic [1:0] c;
                roll = int'($urandom_range(0, 99));
                if (roll < 5)              c = STACK_RSVD;
                else if (roll < 10)        c = STACK_IDLE;
                else if (roll < push_pct)  c = STACK_PUSH;
                else                       c = STACK_POP;
                step("rand", ($urandom_range(0, 99) == 0), c, AW'($urandom),
                     ($urandom_range(0, 15) == 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/nrisc_stack.md
NRISC_STACK -- requirements
Module: nrisc_stack

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 16; number of return-address entries, power of two, 4 to 64.
REQ-002 SHALL have parameter ADDR_W, default 16; return-address width, matching the PC width.
REQ-003 SHALL have port clk, input, 1; the single clock, rising-edge active.
REQ-004 SHALL have port rst, input, 1; reset, synchronous and active-high.
REQ-005 SHALL have port STACK_ctrl, input, 2; command from the CPU: 2'b00 idle, 2'b01 push (CALL), 2'b10 pop (RET/RETI), 2'b11 reserved.
REQ-006 SHALL have port STACK_DataIN, input, ADDR_W; return address to push.
REQ-007 SHALL have port STACK_DataOUT, output, ADDR_W; registered top-of-stack value presented to the PC mux.
REQ-008 SHALL have port STACK_count, output, log2(STACK_DEPTH)+1; number of valid entries.
REQ-009 SHALL have ports STACK_empty and STACK_full, outputs, 1 each; count==0 and count==STACK_DEPTH respectively.
REQ-010 SHALL have port STACK_pop_valid, output, 1; one-cycle pulse in the cycle after an accepted pop.
REQ-011 SHALL have ports STACK_overflow and STACK_underflow (outputs, 1 each) and STACK_err_clr (input, 1) when NRISC_STACK_ERR_EN is defined.

Function
REQ-012 SHALL sample STACK_ctrl on every rising clk edge; each command acts for exactly one edge.
REQ-013 SHALL, on a push when not full, write STACK_DataIN at index count, increment count, and set STACK_DataOUT to STACK_DataIN at that same edge.
REQ-014 SHALL, on a push when full, leave storage, count and STACK_DataOUT unchanged (push dropped).
REQ-015 SHALL, on a pop when not empty, decrement count, set STACK_DataOUT to entry count-2 (or 0 if the stack becomes empty), and assert STACK_pop_valid on the following cycle.
REQ-016 SHALL, on a pop when empty, leave all state unchanged and not pulse STACK_pop_valid.
REQ-017 SHALL treat 2'b11 as idle, with no state change.
REQ-018 SHALL keep STACK_DataOUT equal to the stored value at index count-1 whenever count>0, and 0 otherwise.
REQ-019 SHALL derive STACK_empty and STACK_full combinationally from count, so they are valid in the same cycle count changes.
REQ-020 SHALL implement a two-state controller, IDLE and POPPED: an accepted pop moves IDLE->POPPED; POPPED returns to IDLE on the next edge; STACK_pop_valid is asserted in POPPED. An accepted pop while in POPPED stays in POPPED.

Reset
REQ-021 SHALL, on rst high at a rising edge, set count=0, STACK_DataOUT=0, STACK_pop_valid=0, state=IDLE, and the error flags to 0.
REQ-022 SHALL give rst priority over any simultaneous STACK_ctrl command; the storage array contents need no reset.
REQ-023 SHALL abandon a pending POPPED state on reset, so no STACK_pop_valid pulse follows the reset.

Configuration
REQ-024 SHALL, with NRISC_STACK_ERR_EN defined, set STACK_overflow sticky on a dropped push and STACK_underflow sticky on a dropped pop.
REQ-025 SHALL clear both error flags on STACK_err_clr; a same-edge error event takes priority over clear, so the flag remains set.
REQ-026 SHALL, with NRISC_STACK_ERR_EN undefined, omit the error ports and logic; push/pop behaviour is otherwise identical.

Structure
REQ-027 SHALL take the STACK_ctrl encoding constants (STACK_IDLE, STACK_PUSH, STACK_POP) and the default ADDR_W from the shared package nrisc_pkg, which the CPU control unit also uses.
REQ-028 SHALL place storage in the sub-module nrisc_stack_ram: a single-port synchronous write array with asynchronous read, STACK_DEPTH x ADDR_W.

Verification
REQ-029 SHALL cover: reset, then push 0x0100 -> STACK_DataOUT=0x0100, count=1, empty=0.
REQ-030 SHALL cover: push 0x0100, 0x0200, 0x0300, then pop -> STACK_DataOUT=0x0200, count=2, STACK_pop_valid high for exactly one cycle after the pop.
REQ-031 SHALL cover: 16 pushes of 0x1000+i, then push 0xDEAD -> full=1, count=16, STACK_DataOUT=0x100F, overflow=1 (ERR_EN).
REQ-032 SHALL cover: pop on empty -> count=0, STACK_DataOUT=0, no pop_valid pulse, underflow=1 (ERR_EN); then err_clr -> underflow=0.
REQ-033 SHALL cover: rst asserted in the same cycle as a pop of a 3-deep stack -> count=0, STACK_DataOUT=0, no pop_valid pulse.
REQ-034 SHALL cover: STACK_ctrl=2'b11 for 5 cycles with 2 entries -> count and STACK_DataOUT unchanged.
